pzvip_gpio_input_filter: RTL and testbench

Synthesizable GPIO input conditioner. It consumes the raw pad-side `value_in` vector driven by the GPIO VIP master or the pad ring. Per bit, it synchronizes the input, debounces it with a programmable glitch filter and detects enabled rising/falling edges into a sticky write-1-to-clear status vector. A single level interrupt is produced from that status. It sits between the GPIO pins and the register block / interrupt controller.

---
 rtl/pzvip_gpio_input_filter.sv | 148 ++++++++++++++
 tb/tb_pzvip_gpio_input_filter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/pzvip_gpio_input_filter.sv
// pzvip_gpio_input_filter
//   GPIO input conditioner. Each bit is synchronized, debounced by a
//   programmable glitch filter, and edge-detected into a sticky W1C status
//   vector. A single level interrupt is raised from the masked status.
//
// Ports
//   clk, reset_n      : clock, asynchronous active-low reset
//   value_in          : raw asynchronous pad inputs
//   debounce_cycles   : filter threshold N (change must persist N+1 cycles)
//   rise_enable       : per-bit rising-edge capture enable
//   fall_enable       : per-bit falling-edge capture enable
//   int_enable        : per-bit interrupt mask
//   status_clear      : per-bit write-1-to-clear pulse
//   value             : filtered level
//   status            : sticky edge flags
//   irq               : registered OR of (status & int_enable)

// Per-bit lane: synchronizer, debounce counter, filtered level, status flag.
module pzvip_gpio_input_filter_lane #(
  parameter int SYNC_STAGES    = 2,
  parameter int DEBOUNCE_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      din,
  input  logic                      armed,
  input  logic [DEBOUNCE_WIDTH-1:0] n,
  input  logic                      rise_en,
  input  logic                      fall_en,
  input  logic                      clr,
  output logic                      value,
  output logic                      status,
  output logic                      status_nxt
);
  logic [SYNC_STAGES-1:0]    sync_q, sync_d;
  logic [DEBOUNCE_WIDTH-1:0] cnt_q, cnt_d;
  logic                      val_q, val_d;
  logic                      status_q, status_d;
  logic                      s, s_nxt, rise, fall;

  assign s     = sync_q[SYNC_STAGES-1];
  // Value the last sync stage takes at this edge; used during arming so the
  // filtered level lands together with the synchronizer output.
  assign s_nxt = sync_q[SYNC_STAGES-2];

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din};
    val_d  = val_q;
    cnt_d  = cnt_q;
    if (!armed) begin
      val_d = s_nxt;
      cnt_d = '0;
    end else if (s == val_q) begin
      cnt_d = '0;
    end else if (cnt_q >= n) begin
      val_d = s;
      cnt_d = '0;
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + DEBOUNCE_WIDTH'(1);
    end
    rise     = armed & ~val_q &  val_d & rise_en;
    fall     = armed &  val_q & ~val_d & fall_en;
    // New events take priority over a coincident clear.
    status_d = (status_q & ~clr) | rise | fall;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      val_q    <= 1'b0;
      status_q <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      cnt_q    <= cnt_d;
      val_q    <= val_d;
      status_q <= status_d;
    end
  end

  assign value      = val_q;
  assign status     = status_q;
  assign status_nxt = status_d;
endmodule

module pzvip_gpio_input_filter #(
  parameter int WIDTH          = 32,
  parameter int SYNC_STAGES    = 2,   // legal 2..4
  parameter int DEBOUNCE_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [WIDTH-1:0]          value_in,
  input  logic [DEBOUNCE_WIDTH-1:0] debounce_cycles,
  input  logic [WIDTH-1:0]          rise_enable,
  input  logic [WIDTH-1:0]          fall_enable,
  input  logic [WIDTH-1:0]          int_enable,
  input  logic [WIDTH-1:0]          status_clear,
  output logic [WIDTH-1:0]          value,
  output logic [WIDTH-1:0]          status,
  output logic                      irq
);
  logic [2:0]       arm_cnt_q, arm_cnt_d;
  logic             armed;
  logic [WIDTH-1:0] status_nxt;
  logic             irq_q, irq_d;

  // Arm phase: SYNC_STAGES cycles after reset release during which the
  // filtered level is loaded straight from the synchronizer, so a level held
  // through reset never looks like an edge.
  assign armed = (arm_cnt_q == 3'(SYNC_STAGES));

  always_comb begin
    arm_cnt_d = armed ? arm_cnt_q : arm_cnt_q + 3'd1;
    irq_d     = |(status_nxt & int_enable);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      arm_cnt_q <= '0;
      irq_q     <= 1'b0;
    end else begin
      arm_cnt_q <= arm_cnt_d;
      irq_q     <= irq_d;
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_lane
    pzvip_gpio_input_filter_lane #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_WIDTH (DEBOUNCE_WIDTH)
    ) u_lane (
      .clk        (clk),
      .reset_n    (reset_n),
      .din        (value_in[g]),
      .armed      (armed),
      .n          (debounce_cycles),
      .rise_en    (rise_enable[g]),
      .fall_en    (fall_enable[g]),
      .clr        (status_clear[g]),
      .value      (value[g]),
      .status     (status[g]),
      .status_nxt (status_nxt[g])
    );
  end

  assign irq = irq_q;
endmodule

// File: tb/tb_pzvip_gpio_input_filter.sv
// Directed bench for pzvip_gpio_input_filter: a vector table for the basic
// filter/edge/status/irq function, then hand-written multi-cycle sequences.
module tb_pzvip_gpio_input_filter;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] value_in, rise_enable, fall_enable, int_enable, status_clear;
  logic [7:0]  debounce_cycles;
  logic [31:0] value, status;
  logic        irq;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pzvip_gpio_input_filter dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .value_in        (value_in),
    .debounce_cycles (debounce_cycles),
    .rise_enable     (rise_enable),
    .fall_enable     (fall_enable),
    .int_enable      (int_enable),
    .status_clear    (status_clear),
    .value           (value),
    .status          (status),
    .irq             (irq)
  );

  typedef struct {
    logic [31:0] vin;
    logic [31:0] rise;
    logic [31:0] fall;
    logic [31:0] inten;
    logic [31:0] clr;
    int          ncyc;
    logic [31:0] exp_val;
    logic [31:0] exp_sts;
    logic        exp_irq;
  } vec_t;

  vec_t tbl[9];

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Bring the filtered level to v with N=0 and leave status cleared, irq low.
  task automatic settle(input logic [31:0] v);
    value_in        = v;
    debounce_cycles = 8'd0;
    rise_enable     = '1;
    fall_enable     = '1;
    int_enable      = '0;
    tick(5);
    status_clear = '1;
    tick(1);
    status_clear = '0;
  endtask

  initial begin
    bit stayed;
    // vin, rise, fall, inten, clr, ncyc, exp value, exp status, exp irq
    tbl[0] = '{32'h0000_FFFF, '1, '1, '1, 32'h0, 2, 32'hFFFF_FFFF, 32'h0, 1'b0};
    tbl[1] = '{32'h0000_FFFF, '1, '1, '1, 32'h0, 1, 32'h0000_FFFF, 32'hFFFF_0000, 1'b1};
    tbl[2] = '{32'h0000_FFFF, '1, '1, '1, '1,    1, 32'h0000_FFFF, 32'h0, 1'b0};
    tbl[3] = '{32'h0000_00FF, '0, '1, '1, 32'h0, 3, 32'h0000_00FF, 32'h0000_FF00, 1'b1};
    tbl[4] = '{32'h00FF_00FF, '0, '1, '1, 32'h0, 3, 32'h00FF_00FF, 32'h0000_FF00, 1'b1};
    tbl[5] = '{32'h00FF_00FF, '0, '1, '0, 32'h0000_FF00, 1, 32'h00FF_00FF, 32'h0, 1'b0};
    tbl[6] = '{32'hA5A5_A5A5, '1, '0, '0, 32'h0, 3, 32'hA5A5_A5A5, 32'hA500_A500, 1'b0};
    tbl[7] = '{32'hA5A5_A5A5, '1, '0, 32'h0000_0100, 32'h0, 1, 32'hA5A5_A5A5, 32'hA500_A500, 1'b1};
    tbl[8] = '{32'hA5A5_A5A5, '1, '0, 32'h0000_0100, '1, 1, 32'hA5A5_A5A5, 32'h0, 1'b0};

    // Reset with inputs held high: no rising event after release.
    reset_n = 1'b0; value_in = '1; debounce_cycles = 8'd0;
    rise_enable = '1; fall_enable = '1; int_enable = '1; status_clear = '0;
    tick(3);
    chk("reset_value",  value, 32'h0);
    chk("reset_status", status, 32'h0);
    chk("reset_irq",    {31'b0, irq}, 32'h0);
    reset_n = 1'b1;
    tick(1);
    chk("arm_value_c1", value, 32'h0);
    tick(1);
    chk("arm_value_c2", value, 32'hFFFF_FFFF);
    chk("arm_status_c2", status, 32'h0);
    tick(6);
    chk("arm_status_late", status, 32'h0);
    chk("arm_irq_late", {31'b0, irq}, 32'h0);

    // Table-driven vectors, N=0: status_clear is a one-cycle pulse at row start.
    for (int i = 0; i < 9; i++) begin
      value_in = tbl[i].vin; rise_enable = tbl[i].rise; fall_enable = tbl[i].fall;
      int_enable = tbl[i].inten; status_clear = tbl[i].clr;
      tick(1);
      status_clear = '0;
      if (tbl[i].ncyc > 1) tick(tbl[i].ncyc - 1);
      chk($sformatf("vec%0d_value", i),  value,  tbl[i].exp_val);
      chk($sformatf("vec%0d_status", i), status, tbl[i].exp_sts);
      chk($sformatf("vec%0d_irq", i),    {31'b0, irq}, {31'b0, tbl[i].exp_irq});
    end

    // Bit 3 rise with N=4: value, status and irq change exactly 7 cycles later.
    settle(32'h0);
    debounce_cycles = 8'd4; rise_enable = 32'h8; fall_enable = '0; int_enable = 32'h8;
    value_in = 32'h8;
    tick(6);
    chk("b3_value_c6",  value,  32'h0);
    chk("b3_status_c6", status, 32'h0);
    chk("b3_irq_c6",    {31'b0, irq}, 32'h0);
    tick(1);
    chk("b3_value_c7",  value,  32'h8);
    chk("b3_status_c7", status, 32'h8);
    chk("b3_irq_c7",    {31'b0, irq}, 32'h1);

    // Bit 5: 4-cycle glitch is filtered, 5-cycle pulse propagates (N=4).
    settle(32'h0);
    debounce_cycles = 8'd4; int_enable = '1;
    value_in = 32'h20;
    tick(4);
    value_in = 32'h0;
    stayed = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (value != 32'h0 || status != 32'h0) stayed = 1'b0;
    end
    chk("b5_glitch_filtered", {31'b0, stayed}, 32'h1);
    value_in = 32'h20;
    tick(5);
    value_in = 32'h0;
    tick(2);
    chk("b5_pulse_value",  value,  32'h20);
    chk("b5_pulse_status", status, 32'h20);
    tick(4);
    chk("b5_value_pre_fall", value, 32'h20);
    tick(1);
    chk("b5_value_fall_c7", value, 32'h0);

    // Clear coincident with a new falling edge: set wins; next clear drops it.
    settle(32'h0);
    rise_enable = 32'h8; fall_enable = 32'h8; int_enable = 32'h8;
    value_in = 32'h8;
    tick(3);
    chk("clr_setup_status", status, 32'h8);
    value_in = 32'h0;
    tick(2);
    status_clear = 32'h8;
    tick(1);
    chk("clr_race_value",  value,  32'h0);
    chk("clr_race_status", status, 32'h8);
    chk("clr_race_irq",    {31'b0, irq}, 32'h1);
    tick(1);
    status_clear = '0;
    chk("clr_after_status", status, 32'h0);
    chk("clr_after_irq",    {31'b0, irq}, 32'h0);

    // Bit 0 rise with interrupt masked, then unmask.
    settle(32'h0);
    rise_enable = 32'h1; fall_enable = '0; int_enable = '0;
    value_in = 32'h1;
    tick(3);
    chk("mask_status", status, 32'h1);
    chk("mask_irq",    {31'b0, irq}, 32'h0);
    int_enable = 32'h1;
    tick(1);
    chk("unmask_irq", {31'b0, irq}, 32'h1);

    // Reset mid-count on bit 7 (N=10, counter at 3).
    settle(32'h10);
    debounce_cycles = 8'd10; rise_enable = '1; fall_enable = '1; int_enable = '1;
    value_in = 32'h90;
    tick(5);
    chk("midcnt_value_pre", value, 32'h10);
    reset_n = 1'b0;
    #2;
    chk("midrst_value",  value,  32'h0);
    chk("midrst_status", status, 32'h0);
    chk("midrst_irq",    {31'b0, irq}, 32'h0);
    tick(1);
    reset_n = 1'b1;
    tick(1);
    chk("rearm_value_c1", value, 32'h0);
    tick(1);
    chk("rearm_value_c2", value, 32'h90);
    tick(15);
    chk("rearm_status", status, 32'h0);
    chk("rearm_irq",    {31'b0, irq}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
